// File: rtl/fp32_subtractor_seq_pkg.sv
// ============================================================================
// Module   : fp32_subtractor_seq_pkg
// Brief    : FP32 field positions and FSM state encoding for the serial
//            subtractor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp32_subtractor_seq_pkg;

   localparam int unsigned c_exp_msb = 30;
   localparam int unsigned c_exp_lsb = 23;
   localparam int unsigned c_man_msb = 22;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ALIGN = 3'd1,
      ST_OP    = 3'd2,
      ST_NORM  = 3'd3,
      ST_DONE  = 3'd4
   } fsm_state_t;

endpackage

`default_nettype wire

// File: rtl/fp32_unpack.sv
// ============================================================================
// Module   : fp32_unpack
// Brief    : Splits a float word into sign, effective exponent and mantissa
//            with the hidden bit made explicit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp32_unpack #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic [EXP_W+MAN_W:0] i_word,
   output logic                 o_sign,
   output logic [EXP_W-1:0]     o_exp,
   output logic [MAN_W:0]       o_man
);

   logic w_is_denorm;

   assign w_is_denorm = (i_word[EXP_W+MAN_W-1:MAN_W] == '0);
   assign o_sign      = i_word[EXP_W+MAN_W];
   // Denormals share the scale of exponent 1 but carry no hidden bit.
   assign o_exp       = w_is_denorm ? EXP_W'(1) : i_word[EXP_W+MAN_W-1:MAN_W];
   assign o_man       = {~w_is_denorm, i_word[MAN_W-1:0]};

endmodule

`default_nettype wire

// File: rtl/fp32_subtractor_seq.sv
// ============================================================================
// Module   : fp32_subtractor_seq
// Brief    : Multi-cycle single-precision subtractor (a - b), one alignment or
//            normalisation bit per cycle, truncating, valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp32_subtractor_seq
   import fp32_subtractor_seq_pkg::*;
#(
   parameter int EXP_W = c_exp_msb - c_exp_lsb + 1,
   parameter int MAN_W = c_man_msb + 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [EXP_W+MAN_W:0] i_a,
   input  logic [EXP_W+MAN_W:0] i_b,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [EXP_W+MAN_W:0] o_result
);

   localparam int               c_dp_w      = MAN_W + 2;
   localparam logic [EXP_W-1:0] c_far_shift = EXP_W'(c_dp_w);
   localparam logic [EXP_W:0]   c_exp_inf   = {1'b0, {EXP_W{1'b1}}};
   localparam logic [EXP_W:0]   c_exp_one   = (EXP_W+1)'(1);

   logic             w_sign_a, w_sign_b_raw, w_sign_b;
   logic [EXP_W-1:0] w_exp_a, w_exp_b;
   logic [MAN_W:0]   w_man_a, w_man_b;

   fp32_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
      .i_word (i_a),
      .o_sign (w_sign_a),
      .o_exp  (w_exp_a),
      .o_man  (w_man_a)
   );

   fp32_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
      .i_word (i_b),
      .o_sign (w_sign_b_raw),
      .o_exp  (w_exp_b),
      .o_man  (w_man_b)
   );

   // Subtraction is addition of the negated subtrahend.
   assign w_sign_b = ~w_sign_b_raw;

   logic             w_swap;
   logic             w_sign_l, w_sign_s;
   logic [EXP_W-1:0] w_exp_l, w_exp_s, w_diff;
   logic [MAN_W:0]   w_man_l, w_man_s;
   logic             w_far;

   assign w_swap   = (w_exp_b > w_exp_a);
   assign w_sign_l = w_swap ? w_sign_b : w_sign_a;
   assign w_sign_s = w_swap ? w_sign_a : w_sign_b;
   assign w_exp_l  = w_swap ? w_exp_b  : w_exp_a;
   assign w_exp_s  = w_swap ? w_exp_a  : w_exp_b;
   assign w_man_l  = w_swap ? w_man_b  : w_man_a;
   assign w_man_s  = w_swap ? w_man_a  : w_man_b;
   assign w_diff   = w_exp_l - w_exp_s;
   assign w_far    = (w_diff >= c_far_shift);

   fsm_state_t        r_state;
   logic              r_sign_l, r_sign_s, r_sign;
   logic [EXP_W:0]    r_exp;
   logic [MAN_W:0]    r_man_l, r_man_s;
   logic [EXP_W-1:0]  r_diff;
   logic [c_dp_w-1:0] r_m;
   logic [EXP_W:0]    w_exp_inc;

   assign w_exp_inc = r_exp + c_exp_one;
   assign o_ready   = (r_state == ST_IDLE);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= ST_IDLE;
         r_sign_l <= 1'b0;
         r_sign_s <= 1'b0;
         r_sign   <= 1'b0;
         r_exp    <= '0;
         r_man_l  <= '0;
         r_man_s  <= '0;
         r_diff   <= '0;
         r_m      <= '0;
         o_valid  <= 1'b0;
         o_result <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_valid) begin
                  r_sign_l <= w_sign_l;
                  r_sign_s <= w_sign_s;
                  r_exp    <= {1'b0, w_exp_l};
                  r_man_l  <= w_man_l;
                  // Beyond the datapath width every bit would shift out anyway.
                  r_man_s  <= w_far ? '0 : w_man_s;
                  r_diff   <= w_far ? '0 : w_diff;
                  r_state  <= (w_far || (w_diff == '0)) ? ST_OP : ST_ALIGN;
               end
            end

            ST_ALIGN: begin
               r_man_s <= r_man_s >> 1;
               r_diff  <= r_diff - EXP_W'(1);
               if (r_diff == EXP_W'(1)) begin
                  r_state <= ST_OP;
               end
            end

            ST_OP: begin
               if (r_sign_l == r_sign_s) begin
                  r_m    <= {1'b0, r_man_l} + {1'b0, r_man_s};
                  r_sign <= r_sign_l;
               end else if (r_man_l >= r_man_s) begin
                  r_m    <= {1'b0, r_man_l - r_man_s};
                  r_sign <= r_sign_l;
               end else begin
                  r_m    <= {1'b0, r_man_s - r_man_l};
                  r_sign <= r_sign_s;
               end
               r_state <= ST_NORM;
            end

            ST_NORM: begin
               if (r_m == '0) begin
                  r_sign  <= 1'b0;
                  r_exp   <= '0;
                  r_state <= ST_DONE;
               end else if (r_m[MAN_W+1]) begin
                  r_m   <= r_m >> 1;
                  r_exp <= w_exp_inc;
                  if (w_exp_inc == c_exp_inf) begin
                     r_m     <= '0;
                     r_state <= ST_DONE;
                  end
               end else if (!r_m[MAN_W] && (r_exp > c_exp_one)) begin
                  r_m   <= r_m << 1;
                  r_exp <= r_exp - c_exp_one;
               end else begin
                  // Still unnormalised at the minimum exponent: a denormal.
                  if (!r_m[MAN_W]) begin
                     r_exp <= '0;
                  end
                  r_state <= ST_DONE;
               end
            end

            ST_DONE: begin
               if (!o_valid) begin
                  o_valid  <= 1'b1;
                  o_result <= {r_sign, r_exp[EXP_W-1:0], r_m[MAN_W-1:0]};
               end else if (i_ready) begin
                  o_valid <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fp32_subtractor_seq.sv
// ============================================================================
// Module   : tb_fp32_subtractor_seq
// Brief    : Scoreboard bench for the serial FP32 subtractor: directed spec
//            cases plus randomized operands against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fp32_subtractor_seq;

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b1;
   logic        i_valid = 1'b0;
   logic        i_ready = 1'b0;
   logic [31:0] a       = '0;
   logic [31:0] b       = '0;
   logic        o_ready;
   logic        o_valid;
   logic [31:0] o_result;

   fp32_subtractor_seq dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_valid  (i_valid),
      .o_ready  (o_ready),
      .i_a      (a),
      .i_b      (b),
      .o_valid  (o_valid),
      .i_ready  (i_ready),
      .o_result (o_result)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      int          acc;
      int          lat;
      int          hold;
   } exp_t;

   exp_t sb[$];
   int   n_vec   = 0;
   int   n_err   = 0;
   int   n_cmp   = 0;
   bit   aborted = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: unpack, order, align by truncation, sign-magnitude add, normalise.
   function automatic logic [31:0] model(input logic [31:0] av, input logic [31:0] bv);
      int    ea, eb, el, es, d, e;
      longint ma, mb, ml, ms, m;
      bit    sa, sbn, sl, ss, s;
      logic [31:0] ev;
      sa  = av[31];
      sbn = !bv[31];
      ea  = (av[30:23] == 0) ? 1 : int'(av[30:23]);
      eb  = (bv[30:23] == 0) ? 1 : int'(bv[30:23]);
      ma  = longint'(av[22:0]) + ((av[30:23] != 0) ? 64'd8388608 : 64'd0);
      mb  = longint'(bv[22:0]) + ((bv[30:23] != 0) ? 64'd8388608 : 64'd0);
      if (eb > ea) begin
         el = eb; es = ea; ml = mb; ms = ma; sl = sbn; ss = sa;
      end else begin
         el = ea; es = eb; ml = ma; ms = mb; sl = sa; ss = sbn;
      end
      d = el - es;
      if (d >= 25) ms = 0;
      else         ms = ms / (64'd1 << d);
      if (sl == ss)      begin m = ml + ms; s = sl; end
      else if (ml >= ms) begin m = ml - ms; s = sl; end
      else               begin m = ms - ml; s = ss; end
      e = el;
      if (m == 0) return 32'h0;
      if (m >= 64'd16777216) begin
         m = m / 2;
         e = e + 1;
         if (e == 255) m = 0;
      end else begin
         while (m < 64'd8388608 && e > 1) begin
            m = m * 2;
            e = e - 1;
         end
         if (m < 64'd8388608) e = 0;
      end
      ev = 32'(e);
      return {s, ev[7:0], m[22:0]};
   endfunction

   task automatic timeout(input string what);
      n_err++;
      aborted = 1'b1;
      i_valid = 1'b0;
      $display("FAIL timeout waiting for %s: got no response, expected one within bound", what);
   endtask

   // Issues one operation and waits until the result has been consumed.
   task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic [31:0] req,
                        input int lat, input int hold);
      exp_t e;
      int   t;
      if (aborted) return;
      @(posedge clk); #1;
      a = av; b = bv; i_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!o_ready) begin
         t++;
         if (t > 100) begin timeout("o_ready"); return; end
         @(negedge clk);
      end
      e.res = req; e.acc = cyc + 1; e.lat = lat; e.hold = hold;
      sb.push_back(e);
      n_vec++;
      @(posedge clk); #1 i_valid = 1'b0;
      t = 0;
      @(negedge clk);
      while (sb.size() != 0 || !o_ready || o_valid) begin
         t++;
         if (t > 400) begin timeout("result handshake"); return; end
         @(negedge clk);
      end
   endtask

   function automatic logic [31:0] rnd_fp(input int e);
      logic [31:0] r;
      r = $urandom;
      return {r[31], 8'(e), r[22:0]};
   endfunction

   // Monitor: pops the scoreboard whenever the DUT presents a result.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (o_valid === 1'b1) begin
            i_ready = 1'b0;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL unexpected output: got %h, expected no result", o_result);
               i_ready = 1'b1;
               @(posedge clk); #1 i_ready = 1'b0;
            end else begin
               e = sb.pop_front();
               check("result", o_result, e.res);
               if (e.lat > 0) check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
               for (int k = 0; k < e.hold; k++) begin
                  @(negedge clk);
                  check("hold o_valid", {31'd0, o_valid}, 32'd1);
                  check("hold o_result", o_result, e.res);
                  check("hold o_ready", {31'd0, o_ready}, 32'd0);
               end
               i_ready = 1'b1;
               @(posedge clk); #1 i_ready = 1'b0;
               check("o_valid after accept", {31'd0, o_valid}, 32'd0);
            end
         end else begin
            i_ready = 1'($urandom_range(0, 1));
         end
      end
   end

   initial begin
      int ea, eb, mode;
      logic [31:0] av, bv;

      #1 rst_n = 1'b0;
      #1;
      check("reset o_valid", {31'd0, o_valid}, 32'd0);
      check("reset o_result", o_result, 32'd0);
      check("reset o_ready", {31'd0, o_ready}, 32'd1);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      issue(32'h40400000, 32'h3F800000, 32'h40000000, 5, 0);
      issue(32'h3F800000, 32'h3F800000, 32'h00000000, 4, 0);
      issue(32'h3F800000, 32'hBF800000, 32'h40000000, 5, 0);
      issue(32'h3F800000, 32'h3FC00000, 32'hBF000000, 5, 0);
      issue(32'h4B800000, 32'h3F800000, 32'h4B800000, 28, 0);
      issue(32'h53800000, 32'h3F800000, 32'h53800000, 4, 0);
      issue(32'h00000003, 32'h00000001, 32'h00000002, 4, 0);
      issue(32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 4, 0);
      issue(32'h40400000, 32'h3F800000, 32'h40000000, 5, 5);

      // Reset during ALIGN must abort with no result ever appearing.
      if (!aborted) begin
         @(posedge clk); #1;
         a = 32'h4B800000; b = 32'h3F800000; i_valid = 1'b1;
         @(posedge clk); #1 i_valid = 1'b0;
         repeat (3) @(posedge clk);
         @(negedge clk);
         check("busy in ALIGN o_ready", {31'd0, o_ready}, 32'd0);
         #1 rst_n = 1'b0;
         #1;
         check("abort o_valid", {31'd0, o_valid}, 32'd0);
         @(posedge clk); #1 rst_n = 1'b1;
         repeat (40) @(negedge clk);
         check("after abort o_valid", {31'd0, o_valid}, 32'd0);
         check("after abort o_ready", {31'd0, o_ready}, 32'd1);
      end

      for (int i = 0; i < 150; i++) begin
         mode = $urandom_range(0, 9);
         if (mode == 0)      ea = 0;
         else if (mode == 1) ea = $urandom_range(253, 255);
         else                ea = $urandom_range(1, 254);
         av = rnd_fp(ea);
         mode = $urandom_range(0, 9);
         if (mode <= 4)      eb = ea + $urandom_range(0, 6) - 3;
         else if (mode <= 6) eb = $urandom_range(0, 255);
         else                eb = ea;
         if (eb < 0)   eb = 0;
         if (eb > 255) eb = 255;
         bv = rnd_fp(eb);
         if (mode >= 8) bv = {bv[31], av[30:0] ^ 31'($urandom_range(0, 255))};
         issue(av, bv, model(av, bv), 0, $urandom_range(0, 2));
      end

      repeat (5) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
